// File: rtl/pregfile_mp.sv
// Multi-port physical register file with an integrated ready scoreboard.
// N CDB write ports, M read-port pairs, rename-time ready clear, optional write->read bypass.
module pregfile_mp #(
    parameter int NUM_PREGS = 64,
    parameter int IDX_W     = 6,
    parameter int NUM_WR    = 2,
    parameter int NUM_RD    = 3,
    parameter int NUM_ALLOC = 1,
    parameter bit BYPASS    = 1'b1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic [NUM_WR-1:0]            wr_valid,
    input  logic [NUM_WR*IDX_W-1:0]      wr_idx,
    input  logic [NUM_WR*32-1:0]         wr_data,
    input  logic [NUM_ALLOC-1:0]         alloc_valid,
    input  logic [NUM_ALLOC*IDX_W-1:0]   alloc_idx,
    input  logic [NUM_RD*IDX_W-1:0]      rd_idx1,
    input  logic [NUM_RD*IDX_W-1:0]      rd_idx2,
    output logic [NUM_RD*32-1:0]         rd_data1,
    output logic [NUM_RD*32-1:0]         rd_data2,
    input  logic [2*NUM_ALLOC*IDX_W-1:0] rdy_q_idx,
    output logic [2*NUM_ALLOC-1:0]       rdy_q
);

    logic [31:0]          data_q [NUM_PREGS];
    logic [NUM_PREGS-1:0] ready_q;

    // Entry 0 is never written, so its data/ready bits stay at their reset constants.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int p = 0; p < NUM_PREGS; p++) begin
                data_q[p] <= '0;
            end
            ready_q <= '1;
        end else begin
            // Ascending port order: the highest port index wins a collision.
            for (int i = 0; i < NUM_WR; i++) begin
                if (wr_valid[i] && wr_idx[i*IDX_W +: IDX_W] != '0) begin
                    data_q[wr_idx[i*IDX_W +: IDX_W]]  <= wr_data[i*32 +: 32];
                    ready_q[wr_idx[i*IDX_W +: IDX_W]] <= 1'b1;
                end
            end
            // Alloc is applied after CDB sets: the CDB producer is older than the new owner.
            if (flush) begin
                ready_q <= '1;
            end else begin
                for (int k = 0; k < NUM_ALLOC; k++) begin
                    if (alloc_valid[k] && alloc_idx[k*IDX_W +: IDX_W] != '0) begin
                        ready_q[alloc_idx[k*IDX_W +: IDX_W]] <= 1'b0;
                    end
                end
            end
        end
    end

    function automatic logic [31:0] read_preg(input logic [IDX_W-1:0] idx);
        logic [31:0] val;
        val = data_q[idx];
        if (BYPASS) begin
            for (int i = 0; i < NUM_WR; i++) begin
                if (wr_valid[i] && wr_idx[i*IDX_W +: IDX_W] == idx) begin
                    val = wr_data[i*32 +: 32];
                end
            end
        end
        if (rst || idx == '0) begin
            val = '0;
        end
        return val;
    endfunction

    // Same-cycle CDB writes forward their set; same-cycle allocs are not visible yet.
    function automatic logic query_ready(input logic [IDX_W-1:0] idx);
        logic rdy;
        rdy = ready_q[idx];
        for (int i = 0; i < NUM_WR; i++) begin
            if (wr_valid[i] && wr_idx[i*IDX_W +: IDX_W] == idx) begin
                rdy = 1'b1;
            end
        end
        if (rst || idx == '0) begin
            rdy = 1'b1;
        end
        return rdy;
    endfunction

    always_comb begin
        rd_data1 = '0;
        rd_data2 = '0;
        for (int j = 0; j < NUM_RD; j++) begin
            rd_data1[j*32 +: 32] = read_preg(rd_idx1[j*IDX_W +: IDX_W]);
            rd_data2[j*32 +: 32] = read_preg(rd_idx2[j*IDX_W +: IDX_W]);
        end
    end

    always_comb begin
        rdy_q = '0;
        for (int q = 0; q < 2*NUM_ALLOC; q++) begin
            rdy_q[q] = query_ready(rdy_q_idx[q*IDX_W +: IDX_W]);
        end
    end

endmodule

// File: tb/tb_pregfile_mp.sv
// Bench for pregfile_mp: a bypassing and a non-bypassing instance share stimulus and are
// checked every cycle against a rule-level model, plus directed literal expectations.
module tb_pregfile_mp;
    localparam int IDX_W     = 6;
    localparam int NUM_PREGS = 64;
    localparam int NUM_WR    = 2;
    localparam int NUM_RD    = 3;
    localparam int NUM_ALLOC = 1;

    logic                         clk = 1'b0;
    logic                         rst;
    logic                         flush;
    logic [NUM_WR-1:0]            wr_valid;
    logic [NUM_WR*IDX_W-1:0]      wr_idx;
    logic [NUM_WR*32-1:0]         wr_data;
    logic [NUM_ALLOC-1:0]         alloc_valid;
    logic [NUM_ALLOC*IDX_W-1:0]   alloc_idx;
    logic [NUM_RD*IDX_W-1:0]      rd_idx1, rd_idx2;
    logic [NUM_RD*32-1:0]         rd1_b, rd2_b, rd1_n, rd2_n;
    logic [2*NUM_ALLOC*IDX_W-1:0] rdy_q_idx;
    logic [2*NUM_ALLOC-1:0]       rdy_b, rdy_n;

    int n_pass = 0;
    int n_chk  = 0;

    pregfile_mp #(.NUM_PREGS(NUM_PREGS), .IDX_W(IDX_W), .NUM_WR(NUM_WR), .NUM_RD(NUM_RD),
                  .NUM_ALLOC(NUM_ALLOC), .BYPASS(1'b1)) dut_byp (
        .clk(clk), .rst(rst), .flush(flush),
        .wr_valid(wr_valid), .wr_idx(wr_idx), .wr_data(wr_data),
        .alloc_valid(alloc_valid), .alloc_idx(alloc_idx),
        .rd_idx1(rd_idx1), .rd_idx2(rd_idx2), .rd_data1(rd1_b), .rd_data2(rd2_b),
        .rdy_q_idx(rdy_q_idx), .rdy_q(rdy_b)
    );

    pregfile_mp #(.NUM_PREGS(NUM_PREGS), .IDX_W(IDX_W), .NUM_WR(NUM_WR), .NUM_RD(NUM_RD),
                  .NUM_ALLOC(NUM_ALLOC), .BYPASS(1'b0)) dut_nob (
        .clk(clk), .rst(rst), .flush(flush),
        .wr_valid(wr_valid), .wr_idx(wr_idx), .wr_data(wr_data),
        .alloc_valid(alloc_valid), .alloc_idx(alloc_idx),
        .rd_idx1(rd_idx1), .rd_idx2(rd_idx2), .rd_data1(rd1_n), .rd_data2(rd2_n),
        .rdy_q_idx(rdy_q_idx), .rdy_q(rdy_n)
    );

    always #5 clk = ~clk;

    // Architectural state of the register file as the rules define it.
    logic [31:0] m_data  [NUM_PREGS];
    logic        m_ready [NUM_PREGS];

    always @(posedge clk) begin
        if (rst) begin
            for (int p = 0; p < NUM_PREGS; p++) begin
                m_data[p]  = 32'h0;
                m_ready[p] = 1'b1;
            end
        end else begin
            for (int i = 0; i < NUM_WR; i++) begin
                if (wr_valid[i] && wr_idx[i*IDX_W +: IDX_W] != 0) begin
                    m_data[wr_idx[i*IDX_W +: IDX_W]]  = wr_data[i*32 +: 32];
                    m_ready[wr_idx[i*IDX_W +: IDX_W]] = 1'b1;
                end
            end
            if (flush) begin
                for (int p = 0; p < NUM_PREGS; p++) m_ready[p] = 1'b1;
            end else begin
                for (int k = 0; k < NUM_ALLOC; k++) begin
                    if (alloc_valid[k] && alloc_idx[k*IDX_W +: IDX_W] != 0)
                        m_ready[alloc_idx[k*IDX_W +: IDX_W]] = 1'b0;
                end
            end
        end
    end

    function automatic logic [31:0] exp_rd(input logic [IDX_W-1:0] idx, input bit byp);
        logic [31:0] v;
        if (rst || idx == 0) return 32'h0;
        v = m_data[idx];
        if (byp) begin
            for (int i = 0; i < NUM_WR; i++) begin
                if (wr_valid[i] && wr_idx[i*IDX_W +: IDX_W] == idx) v = wr_data[i*32 +: 32];
            end
        end
        return v;
    endfunction

    function automatic logic exp_rdy(input logic [IDX_W-1:0] idx);
        if (rst || idx == 0) return 1'b1;
        for (int i = 0; i < NUM_WR; i++) begin
            if (wr_valid[i] && wr_idx[i*IDX_W +: IDX_W] == idx) return 1'b1;
        end
        return m_ready[idx];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    always @(negedge clk) begin
        assert (!(wr_valid[0] && wr_valid[1] && wr_idx[5:0] == wr_idx[11:6] && wr_idx[5:0] != 0))
            else $error("illegal CDB write collision in stimulus");
        for (int j = 0; j < NUM_RD; j++) begin
            chk($sformatf("model byp rd1[%0d]", j), rd1_b[j*32 +: 32], exp_rd(rd_idx1[j*IDX_W +: IDX_W], 1'b1));
            chk($sformatf("model byp rd2[%0d]", j), rd2_b[j*32 +: 32], exp_rd(rd_idx2[j*IDX_W +: IDX_W], 1'b1));
            chk($sformatf("model nob rd1[%0d]", j), rd1_n[j*32 +: 32], exp_rd(rd_idx1[j*IDX_W +: IDX_W], 1'b0));
            chk($sformatf("model nob rd2[%0d]", j), rd2_n[j*32 +: 32], exp_rd(rd_idx2[j*IDX_W +: IDX_W], 1'b0));
        end
        for (int q = 0; q < 2*NUM_ALLOC; q++) begin
            chk($sformatf("model byp rdy[%0d]", q), 32'(rdy_b[q]), 32'(exp_rdy(rdy_q_idx[q*IDX_W +: IDX_W])));
            chk($sformatf("model nob rdy[%0d]", q), 32'(rdy_n[q]), 32'(exp_rdy(rdy_q_idx[q*IDX_W +: IDX_W])));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; wr_valid = '0; wr_idx = '0; wr_data = '0;
        alloc_valid = '0; alloc_idx = '0; rd_idx1 = '0; rd_idx2 = '0; rdy_q_idx = '0;
        tick();
        rd_idx1 = {6'd9, 6'd5, 6'd63}; rd_idx2 = {6'd1, 6'd2, 6'd3}; rdy_q_idx = {6'd12, 6'd63};
        @(negedge clk);
        chk("rst rd1 idx63", rd1_b[31:0], 32'h0);
        chk("rst rdy", 32'(rdy_b), 32'h3);
        tick();
        rst = 1'b0;

        // T1: sweep every index across all ports after reset
        for (int i = 0; i < NUM_PREGS; i++) begin
            logic [IDX_W-1:0] a, b;
            a = IDX_W'(i);
            b = IDX_W'(NUM_PREGS - 1 - i);
            rd_idx1 = {a, a, a}; rd_idx2 = {b, b, b}; rdy_q_idx = {a, b};
            @(negedge clk);
            if (i == 33) begin
                chk("t1 rd2 idx30", rd2_n[63:32], 32'h0);
                chk("t1 rdy 33/30", 32'(rdy_b), 32'h3);
            end
            tick();
        end

        // T2: write idx5 on port0, write idx0 on port1
        wr_valid = 2'b11; wr_idx = {6'd0, 6'd5}; wr_data = {32'h0000_1234, 32'hDEAD_BEEF};
        rd_idx1 = '0; rd_idx2 = '0; rdy_q_idx = '0;
        @(negedge clk); tick();
        wr_valid = '0; rd_idx1 = {6'd0, 6'd0, 6'd5}; rd_idx2 = '0;
        @(negedge clk);
        chk("t2 rd idx5 byp", rd1_b[31:0], 32'hDEAD_BEEF);
        chk("t2 rd idx5 nob", rd1_n[31:0], 32'hDEAD_BEEF);
        chk("t2 rd idx0", rd2_b[31:0], 32'h0);
        tick();

        // T3: same-cycle bypass, then a split bypass across both ports
        wr_valid = 2'b01; wr_idx = {6'd0, 6'd9}; wr_data = {32'h0, 32'h1111_1111}; rd_idx1 = '0;
        @(negedge clk); tick();
        wr_valid = 2'b10; wr_idx = {6'd9, 6'd0}; wr_data = {32'hA5A5_A5A5, 32'h0};
        rd_idx1 = {6'd9, 6'd0, 6'd0}; rd_idx2 = {6'd9, 6'd0, 6'd0};
        @(negedge clk);
        chk("t3 byp rd1", rd1_b[95:64], 32'hA5A5_A5A5);
        chk("t3 byp rd2", rd2_b[95:64], 32'hA5A5_A5A5);
        chk("t3 nob rd1 old", rd1_n[95:64], 32'h1111_1111);
        chk("t3 nob rd2 old", rd2_n[95:64], 32'h1111_1111);
        tick();
        wr_valid = '0;
        @(negedge clk);
        chk("t3 nob rd1 new", rd1_n[95:64], 32'hA5A5_A5A5);
        tick();
        wr_valid = 2'b11; wr_idx = {6'd34, 6'd33}; wr_data = {32'hBBBB_0034, 32'hAAAA_0033};
        rd_idx1 = {6'd0, 6'd33, 6'd0}; rd_idx2 = {6'd0, 6'd34, 6'd0};
        @(negedge clk);
        chk("t3 split rd1", rd1_b[63:32], 32'hAAAA_0033);
        chk("t3 split rd2", rd2_b[63:32], 32'hBBBB_0034);
        tick();

        // T4: scoreboard clear and CDB set-forwarding
        wr_valid = '0; alloc_valid = 1'b1; alloc_idx = 6'd12; rdy_q_idx = {6'd12, 6'd12};
        @(negedge clk);
        chk("t4 alloc same cycle", 32'(rdy_b), 32'h3);
        tick();
        alloc_valid = 1'b0;
        @(negedge clk);
        chk("t4 after alloc byp", 32'(rdy_b), 32'h0);
        chk("t4 after alloc nob", 32'(rdy_n), 32'h0);
        tick();
        wr_valid = 2'b01; wr_idx = {6'd0, 6'd12}; wr_data = {32'h0, 32'h1234_5678};
        @(negedge clk);
        chk("t4 forwarded", 32'(rdy_b), 32'h3);
        tick();
        wr_valid = '0;
        @(negedge clk);
        chk("t4 after write", 32'(rdy_b), 32'h3);
        tick();

        // T5: alloc and CDB write to the same preg in one cycle
        alloc_valid = 1'b1; alloc_idx = 6'd20;
        wr_valid = 2'b01; wr_idx = {6'd0, 6'd20}; wr_data = {32'h0, 32'h7};
        rd_idx1 = {6'd0, 6'd0, 6'd20}; rdy_q_idx = {6'd20, 6'd20};
        @(negedge clk); tick();
        alloc_valid = 1'b0; wr_valid = '0;
        @(negedge clk);
        chk("t5 data", rd1_n[31:0], 32'h7);
        chk("t5 ready", 32'(rdy_b), 32'h0);
        tick();

        // T6: flush restores ready, keeps CDB data, drops the flush-cycle alloc
        alloc_valid = 1'b1; alloc_idx = 6'd3;
        @(negedge clk); tick();
        alloc_idx = 6'd4;
        @(negedge clk); tick();
        alloc_idx = 6'd30; rdy_q_idx = {6'd3, 6'd4};
        @(negedge clk);
        chk("t6 before flush", 32'(rdy_b), 32'h0);
        tick();
        alloc_idx = 6'd40; flush = 1'b1;
        wr_valid = 2'b01; wr_idx = {6'd0, 6'd7}; wr_data = {32'h0, 32'h55};
        rdy_q_idx = {6'd30, 6'd40};
        @(negedge clk); tick();
        alloc_valid = 1'b0; flush = 1'b0; wr_valid = '0;
        @(negedge clk);
        chk("t6 rdy 30/40", 32'(rdy_b), 32'h3);
        tick();
        rdy_q_idx = {6'd3, 6'd4}; rd_idx1 = {6'd0, 6'd0, 6'd7};
        @(negedge clk);
        chk("t6 rdy 3/4", 32'(rdy_n), 32'h3);
        chk("t6 data7", rd1_b[31:0], 32'h55);
        tick();
        rst = 1'b1; flush = 1'b1;
        @(negedge clk); tick();
        rst = 1'b0; flush = 1'b0;
        @(negedge clk);
        chk("t6 rst+flush data7", rd1_b[31:0], 32'h0);
        chk("t6 rst+flush data7 nob", rd1_n[31:0], 32'h0);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
